// File: rtl/arcade_input_pkg.sv
// -----------------------------------------------------------------------------
// arcade_input_pkg
// Shared constants for the arcade input decoder: PS/2 scan codes, joystick bit
// positions, the default coin pulse length, the key-state index enum and the
// scan-code lookup used by the decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package arcade_input_pkg;

  // 100 ms at 12 MHz
  localparam logic [23:0] COIN_MIN_DEFAULT = 24'd1_200_000;

  // Bit positions inside the 16-bit joystick words
  localparam int J_RIGHT  = 0;
  localparam int J_LEFT   = 1;
  localparam int J_DOWN   = 2;
  localparam int J_UP     = 3;
  localparam int J_FIRE   = 4;
  localparam int J_START1 = 5;
  localparam int J_START2 = 6;
  localparam int J_COIN   = 7;

  // Arrow keys are matched on the low byte only (bit 8 ignored)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Everything else needs the full 9-bit code, extended flag included
  localparam logic [8:0] SC_SPACE    = 9'h029;
  localparam logic [8:0] SC_CTRL     = 9'h014;
  localparam logic [8:0] SC_F1       = 9'h005;
  localparam logic [8:0] SC_1        = 9'h016;
  localparam logic [8:0] SC_F2       = 9'h006;
  localparam logic [8:0] SC_2        = 9'h01E;
  localparam logic [8:0] SC_5        = 9'h02E;
  localparam logic [8:0] SC_6        = 9'h036;
  localparam logic [8:0] SC_P2_UP    = 9'h02D;
  localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
  localparam logic [8:0] SC_P2_LEFT  = 9'h023;
  localparam logic [8:0] SC_P2_RIGHT = 9'h034;
  localparam logic [8:0] SC_P2_FIRE  = 9'h01C;

  localparam int NUM_KEYS = 16;

  // One key-state bit per entry; space and ctrl share KEY_FIRE
  typedef enum logic [3:0] {
    KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_FIRE,
    KEY_F1, KEY_1, KEY_F2, KEY_2, KEY_5, KEY_6,
    KEY_P2_UP, KEY_P2_DOWN, KEY_P2_LEFT, KEY_P2_RIGHT, KEY_P2_FIRE
  } key_id_t;

  typedef struct packed {
    logic    hit;
    key_id_t id;
  } key_lookup_t;

  function automatic key_lookup_t decode_scan(input logic [8:0] code);
    key_lookup_t r;
    r.hit = 1'b1;
    r.id  = KEY_UP;
    if (code[7:0] == SC_UP) begin
      r.id = KEY_UP;
    end else if (code[7:0] == SC_DOWN) begin
      r.id = KEY_DOWN;
    end else if (code[7:0] == SC_LEFT) begin
      r.id = KEY_LEFT;
    end else if (code[7:0] == SC_RIGHT) begin
      r.id = KEY_RIGHT;
    end else begin
      case (code)
        SC_SPACE, SC_CTRL: r.id = KEY_FIRE;
        SC_F1:             r.id = KEY_F1;
        SC_1:              r.id = KEY_1;
        SC_F2:             r.id = KEY_F2;
        SC_2:              r.id = KEY_2;
        SC_5:              r.id = KEY_5;
        SC_6:              r.id = KEY_6;
        SC_P2_UP:          r.id = KEY_P2_UP;
        SC_P2_DOWN:        r.id = KEY_P2_DOWN;
        SC_P2_LEFT:        r.id = KEY_P2_LEFT;
        SC_P2_RIGHT:       r.id = KEY_P2_RIGHT;
        SC_P2_FIRE:        r.id = KEY_P2_FIRE;
        default:           r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/arcade_input_decoder_if.sv
// -----------------------------------------------------------------------------
// arcade_input_decoder_if
// Bundles the decoder's input sources and decoded control outputs.
//   ps2_key[10:0]         : [10] toggle, [9] pressed, [8] extended, [7:0] code
//   joystick_0/1[15:0]    : [0] R [1] L [2] D [3] U [4] fire [5] st1 [6] st2 [7] coin
//   no_rotate             : 1 = horizontal-monitor remap of P1 directions
//   p1_*/p2_*, start1/2, coin1, key_event : decoded outputs, active-high
// master = input source side, slave = decoder side.
// -----------------------------------------------------------------------------
interface arcade_input_decoder_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        no_rotate;

  logic p1_up, p1_down, p1_left, p1_right, p1_fire;
  logic p2_up, p2_down, p2_left, p2_right, p2_fire;
  logic start1, start2, coin1;
  logic key_event;

  modport master (
    output ps2_key, joystick_0, joystick_1, no_rotate,
    input  p1_up, p1_down, p1_left, p1_right, p1_fire,
    input  p2_up, p2_down, p2_left, p2_right, p2_fire,
    input  start1, start2, coin1, key_event
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, no_rotate,
    output p1_up, p1_down, p1_left, p1_right, p1_fire,
    output p2_up, p2_down, p2_left, p2_right, p2_fire,
    output start1, start2, coin1, key_event
  );
endinterface

// File: rtl/coin_stretch.sv
// -----------------------------------------------------------------------------
// coin_stretch
// Stretches a coin request to at least COIN_MIN cycles of coin output.
//   clk_sys : system clock        reset_n : synchronous active-low reset
//   req     : coin request (level) coin    : stretched coin, registered
// A rising edge of req while idle loads the counter; further edges while coin
// is high are ignored. coin stays high while the count is non-zero or req is
// still asserted.
// -----------------------------------------------------------------------------
module coin_stretch #(
  parameter logic [23:0] COIN_MIN = arcade_input_pkg::COIN_MIN_DEFAULT
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin
);

  logic [23:0] count_reg;
  logic [23:0] count_next;
  logic        req_reg;
  logic        coin_reg;

  // Saturating decrement; coin is decided on the post-decrement value so a
  // single-cycle request yields exactly COIN_MIN high cycles.
  assign count_next = (count_reg != 24'd0) ? (count_reg - 24'd1) : 24'd0;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      count_reg <= 24'd0;
      req_reg   <= 1'b0;
      coin_reg  <= 1'b0;
    end else begin
      req_reg <= req;
      if (req && !req_reg && !coin_reg) begin
        count_reg <= COIN_MIN;
        coin_reg  <= 1'b1;
      end else begin
        count_reg <= count_next;
        coin_reg  <= (count_next != 24'd0) || req;
      end
    end
  end

  assign coin = coin_reg;

endmodule

// File: rtl/arcade_input_decoder.sv
// -----------------------------------------------------------------------------
// arcade_input_decoder
// Merges PS/2 keyboard events and two joystick words into registered arcade
// cabinet controls.
//   clk_sys : system clock (12 MHz)
//   reset_n : synchronous active-low reset
//   bus     : arcade_input_decoder_if.slave (ps2_key, joysticks, no_rotate in;
//             player controls, start1/2, coin1, key_event out)
// Key presses reach the outputs two edges after the toggle changes (state
// write, then output register); joystick inputs reach them after one edge.
// -----------------------------------------------------------------------------
module arcade_input_decoder
  import arcade_input_pkg::*;
#(
  parameter logic [23:0] COIN_MIN = COIN_MIN_DEFAULT
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  arcade_input_decoder_if.slave  bus
);

  logic                toggle_reg;
  logic                ps2_event;
  key_lookup_t         lookup;
  logic [NUM_KEYS-1:0] key_state_reg;
  logic [NUM_KEYS-1:0] key_state_next;
  logic [15:0]         joy_all;
  logic                unused_joy_high;

  logic up_raw, down_raw, left_raw, right_raw;
  logic p1_up_next, p1_down_next, p1_left_next, p1_right_next;
  logic coin_req;
  logic coin_out;

  // Toggle copy follows ps2_key[10] even in reset, so releasing reset never
  // produces a spurious event.
  always_ff @(posedge clk_sys) begin
    toggle_reg <= bus.ps2_key[10];
  end

  assign ps2_event = bus.ps2_key[10] ^ toggle_reg;
  assign lookup    = decode_scan(bus.ps2_key[8:0]);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      assign key_state_next[gi] =
        (ps2_event && lookup.hit && (int'(lookup.id) == gi)) ? bus.ps2_key[9]
                                                             : key_state_reg[gi];
    end
  endgenerate

  assign joy_all         = bus.joystick_0 | bus.joystick_1;
  assign unused_joy_high = ^joy_all[15:8];

  assign up_raw    = key_state_reg[KEY_UP]    | joy_all[J_UP];
  assign down_raw  = key_state_reg[KEY_DOWN]  | joy_all[J_DOWN];
  assign left_raw  = key_state_reg[KEY_LEFT]  | joy_all[J_LEFT];
  assign right_raw = key_state_reg[KEY_RIGHT] | joy_all[J_RIGHT];

  // Horizontal monitor: the cabinet is turned a quarter, so each physical
  // direction maps to the neighbouring logical one.
  assign p1_up_next    = bus.no_rotate ? left_raw  : up_raw;
  assign p1_down_next  = bus.no_rotate ? right_raw : down_raw;
  assign p1_left_next  = bus.no_rotate ? down_raw  : left_raw;
  assign p1_right_next = bus.no_rotate ? up_raw    : right_raw;

  assign coin_req = key_state_reg[KEY_5] | key_state_reg[KEY_6] | joy_all[J_COIN];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      key_state_reg <= '0;
      bus.key_event <= 1'b0;
      bus.p1_up     <= 1'b0;
      bus.p1_down   <= 1'b0;
      bus.p1_left   <= 1'b0;
      bus.p1_right  <= 1'b0;
      bus.p1_fire   <= 1'b0;
      bus.p2_up     <= 1'b0;
      bus.p2_down   <= 1'b0;
      bus.p2_left   <= 1'b0;
      bus.p2_right  <= 1'b0;
      bus.p2_fire   <= 1'b0;
      bus.start1    <= 1'b0;
      bus.start2    <= 1'b0;
    end else begin
      key_state_reg <= key_state_next;
      bus.key_event <= ps2_event & lookup.hit;
      bus.p1_up     <= p1_up_next;
      bus.p1_down   <= p1_down_next;
      bus.p1_left   <= p1_left_next;
      bus.p1_right  <= p1_right_next;
      bus.p1_fire   <= key_state_reg[KEY_FIRE]     | joy_all[J_FIRE];
      bus.p2_up     <= key_state_reg[KEY_P2_UP]    | joy_all[J_UP];
      bus.p2_down   <= key_state_reg[KEY_P2_DOWN]  | joy_all[J_DOWN];
      bus.p2_left   <= key_state_reg[KEY_P2_LEFT]  | joy_all[J_LEFT];
      bus.p2_right  <= key_state_reg[KEY_P2_RIGHT] | joy_all[J_RIGHT];
      bus.p2_fire   <= key_state_reg[KEY_P2_FIRE]  | joy_all[J_FIRE];
      bus.start1    <= key_state_reg[KEY_F1] | key_state_reg[KEY_1] | joy_all[J_START1];
      bus.start2    <= key_state_reg[KEY_F2] | key_state_reg[KEY_2] | joy_all[J_START2];
    end
  end

  coin_stretch #(
    .COIN_MIN (COIN_MIN)
  ) u_coin_stretch (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (coin_req),
    .coin    (coin_out)
  );

  assign bus.coin1 = coin_out;

endmodule

// File: tb/tb_arcade_input_decoder.sv
// -----------------------------------------------------------------------------
// tb_arcade_input_decoder
// Self-checking bench: joystick vector table, directed key/coin/reset
// sequences and a randomized run, all compared every cycle against a
// name-keyed behavioural model of the cabinet controls.
// -----------------------------------------------------------------------------
module tb_arcade_input_decoder;

  localparam longint COIN = 10;

  typedef struct packed {
    logic p1_up, p1_down, p1_left, p1_right, p1_fire;
    logic p2_up, p2_down, p2_left, p2_right, p2_fire;
    logic start1, start2, coin1, key_event;
  } outs_t;

  typedef struct packed {
    logic [15:0] j0;
    logic [15:0] j1;
    logic        nr;
    outs_t       exp;
  } vec_t;

  logic clk_sys;
  logic reset_n;
  arcade_input_decoder_if bus ();

  arcade_input_decoder #(
    .COIN_MIN (24'd10)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int     checks = 0;
  int     errors = 0;
  outs_t  exp_m;
  bit     held [string];
  logic   tog_m;
  bit     creq_prev;
  longint load_cyc = -1000;
  longint cyc = 0;

  function automatic outs_t got_outs();
    return {bus.p1_up, bus.p1_down, bus.p1_left, bus.p1_right, bus.p1_fire,
            bus.p2_up, bus.p2_down, bus.p2_left, bus.p2_right, bus.p2_fire,
            bus.start1, bus.start2, bus.coin1, bus.key_event};
  endfunction

  function automatic string role(input logic [8:0] c);
    if (c[7:0] == 8'h75) return "up";
    if (c[7:0] == 8'h72) return "down";
    if (c[7:0] == 8'h6B) return "left";
    if (c[7:0] == 8'h74) return "right";
    case (c)
      9'h029, 9'h014: return "fire";
      9'h005: return "f1";
      9'h016: return "one";
      9'h006: return "f2";
      9'h01E: return "two";
      9'h02E: return "five";
      9'h036: return "six";
      9'h02D: return "p2up";
      9'h02B: return "p2down";
      9'h023: return "p2left";
      9'h034: return "p2right";
      9'h01C: return "p2fire";
      default: return "";
    endcase
  endfunction

  function automatic bit hk(input string k);
    return held.exists(k) ? held[k] : 1'b0;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  // Model evaluates what the next edge must produce from the inputs now present.
  task automatic model_step();
    logic [15:0] j;
    logic u, d, l, r, creq;
    string k;
    if (!reset_n) begin
      held.delete();
      exp_m     = '0;
      tog_m     = bus.ps2_key[10];
      creq_prev = 1'b0;
      load_cyc  = -1000;
    end else begin
      j = bus.joystick_0 | bus.joystick_1;
      u = hk("up") | j[3];
      d = hk("down") | j[2];
      l = hk("left") | j[1];
      r = hk("right") | j[0];
      if (bus.no_rotate) begin
        exp_m.p1_up = l; exp_m.p1_down = r; exp_m.p1_left = d; exp_m.p1_right = u;
      end else begin
        exp_m.p1_up = u; exp_m.p1_down = d; exp_m.p1_left = l; exp_m.p1_right = r;
      end
      exp_m.p1_fire  = hk("fire") | j[4];
      exp_m.p2_up    = hk("p2up") | j[3];
      exp_m.p2_down  = hk("p2down") | j[2];
      exp_m.p2_left  = hk("p2left") | j[1];
      exp_m.p2_right = hk("p2right") | j[0];
      exp_m.p2_fire  = hk("p2fire") | j[4];
      exp_m.start1   = hk("f1") | hk("one") | j[5];
      exp_m.start2   = hk("f2") | hk("two") | j[6];
      creq = hk("five") | hk("six") | j[7];
      if (creq && !creq_prev && !exp_m.coin1) load_cyc = cyc;
      exp_m.coin1 = ((cyc - load_cyc) < COIN) || creq;
      creq_prev = creq;
      k = role(bus.ps2_key[8:0]);
      exp_m.key_event = (bus.ps2_key[10] != tog_m) && (k != "");
      if (exp_m.key_event) held[k] = bus.ps2_key[9];
      tog_m = bus.ps2_key[10];
    end
    cyc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_sys);
    #1;
    chk("model", 16'(got_outs()), 16'(exp_m));
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pressed, code};
    tick();
  endtask

  task automatic coin_run(input string name, input logic [63:0] pat, input int want);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      bus.joystick_0 = {8'h00, pat[i], 7'h00};
      tick();
      if (bus.coin1) n++;
    end
    chk(name, 16'(n), 16'(want));
  endtask

  vec_t tbl [8];
  logic [8:0] codes [20];

  initial begin
    // joystick table: J -> outputs one edge later (no keys held, no coin)
    tbl[0] = {16'h0001, 16'h0000, 1'b0, 14'b00010_00010_0000};
    tbl[1] = {16'h0008, 16'h0000, 1'b1, 14'b00010_10000_0000};
    tbl[2] = {16'h0002, 16'h0000, 1'b1, 14'b10000_00100_0000};
    tbl[3] = {16'h0000, 16'h0004, 1'b0, 14'b01000_01000_0000};
    tbl[4] = {16'h0010, 16'h0020, 1'b0, 14'b00001_00001_1000};
    tbl[5] = {16'h0004, 16'h0040, 1'b1, 14'b00100_01000_0100};
    tbl[6] = {16'h0000, 16'h0000, 1'b1, 14'b00000_00000_0000};
    tbl[7] = {16'hFF0F, 16'h0000, 1'b1, 14'b11110_11110_0000};

    codes = '{9'h075, 9'h175, 9'h072, 9'h16B, 9'h074, 9'h029, 9'h014, 9'h005,
              9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036, 9'h02D, 9'h02B, 9'h023,
              9'h034, 9'h01C, 9'h033, 9'h1CC};

    reset_n        = 1'b0;
    bus.ps2_key    = 11'h000;
    bus.joystick_0 = 16'h0000;
    bus.joystick_1 = 16'h0000;
    bus.no_rotate  = 1'b0;
    repeat (3) tick();
    chk("reset_state", 16'(got_outs()), 16'h0000);
    reset_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      bus.joystick_0 = tbl[i].j0;
      bus.joystick_1 = tbl[i].j1;
      bus.no_rotate  = tbl[i].nr;
      tick();
      chk($sformatf("joy_vec%0d", i), 16'(got_outs()), 16'(tbl[i].exp));
    end
    bus.joystick_0 = 16'h0000;
    bus.no_rotate  = 1'b0;
    tick();

    // press up (extended), then release
    send_key(1'b1, 9'h175);
    chk("up_kev_pulse", 16'(bus.key_event), 16'h1);
    chk("up_not_yet", 16'(bus.p1_up), 16'h0);
    tick();
    chk("up_set", 16'(bus.p1_up), 16'h1);
    chk("up_kev_once", 16'(bus.key_event), 16'h0);
    send_key(1'b0, 9'h175);
    tick();
    chk("up_released", 16'(bus.p1_up), 16'h0);

    // back-to-back events, then an unmapped code
    send_key(1'b1, 9'h029);
    send_key(1'b1, 9'h01C);
    chk("second_kev", 16'(bus.key_event), 16'h1);
    tick();
    chk("p1_fire_key", 16'(bus.p1_fire), 16'h1);
    chk("p2_fire_key", 16'(bus.p2_fire), 16'h1);
    send_key(1'b1, 9'h033);
    chk("unmapped_no_kev", 16'(bus.key_event), 16'h0);

    // coin stretcher
    coin_run("coin_pulse1", 64'h1, 10);
    coin_run("coin_held25", 64'h1FF_FFFF, 25);
    coin_run("coin_reedge", 64'h11, 10);

    // reset in the middle of a stretch with toggle high
    bus.joystick_0 = 16'h0080;
    tick();
    bus.joystick_0 = 16'h0000;
    tick();
    tick();
    chk("coin_mid", 16'(bus.coin1), 16'h1);
    bus.ps2_key = 11'h675;
    reset_n     = 1'b0;
    tick();
    chk("mid_reset_outs", 16'(got_outs()), 16'h0000);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_event_after_rst", 16'(bus.key_event), 16'h0);
    end
    chk("fire_cleared", 16'(bus.p1_fire), 16'h0);
    bus.ps2_key[10] = 1'b0;
    tick();
    chk("event_after_toggle", 16'(bus.key_event), 16'h1);
    tick();
    chk("up_after_toggle", 16'(bus.p1_up), 16'h1);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] r0, r1;
      if ($urandom_range(1, 0) == 1) begin
        bus.ps2_key = {~bus.ps2_key[10], 1'($urandom_range(1, 0)), codes[$urandom_range(19, 0)]};
      end
      r0 = 16'($urandom) & 16'($urandom);
      r1 = 16'($urandom) & 16'($urandom);
      r0[7] = ($urandom_range(15, 0) == 0);
      r1[7] = 1'b0;
      bus.joystick_0 = r0;
      bus.joystick_1 = r1;
      if ($urandom_range(49, 0) == 0) bus.no_rotate = ~bus.no_rotate;
      reset_n = ($urandom_range(249, 0) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arcade_input_decoder.md
ARCADE_INPUT_DECODER -- requirements
Module: arcade_input_decoder

Interface
REQ-001 SHALL have parameter COIN_MIN, default 24'd1_200_000, minimum coin1 high time in clk_sys cycles (100 ms at 12 MHz), legal range 1..2^24-1.
REQ-002 SHALL have port clk_sys  in  1  system clock (12 MHz); all logic on its rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended flag, [7:0] scan code.
REQ-005 SHALL have ports joystick_0, joystick_1  in  16 each  [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start1, [6] start2, [7] coin.
REQ-006 SHALL have port no_rotate  in  1  1 = horizontal-monitor remap of P1 directions.
REQ-007 SHALL have ports p1_up, p1_down, p1_left, p1_right, p1_fire  out  1 each  player-1 controls, active-high.
REQ-008 SHALL have ports p2_up, p2_down, p2_left, p2_right, p2_fire  out  1 each  player-2 controls, active-high.
REQ-009 SHALL have ports start1, start2, coin1  out  1 each  cabinet buttons, active-high.
REQ-010 SHALL have port key_event  out  1  one-cycle pulse per accepted mapped key event.

Function
REQ-011 SHALL register ps2_key[10] each cycle and detect an event when it differs from the registered copy.
REQ-012 SHALL, on an event, write ps2_key[9] into the matching key-state bit at that same edge; unmapped codes change no state and raise no key_event.
REQ-013 SHALL match arrows ignoring bit 8: x75 up, x72 down, x6B left, x74 right; all other codes need an exact 9-bit match.
REQ-014 SHALL map: 029 space and 014 ctrl both drive one shared P1 fire bit (last event wins); 005 F1 and 016 "1" drive separate start1 bits; 006 F2 and 01E "2" drive separate start2 bits; 02E "5" and 036 "6" drive separate coin bits; 02D/02B/023/034 P2 up/down/left/right; 01C P2 fire.
REQ-015 SHALL pulse key_event one cycle after the detecting edge.
REQ-016 SHALL process events on consecutive cycles independently, without loss.
REQ-017 SHALL form J = joystick_0 | joystick_1 and register all outputs: key-to-output latency 2 edges, joystick-to-output latency 1 edge.
REQ-018 SHALL drive P1 with no_rotate=0 as: up = kUp|J[3], down = kDown|J[2], left = kLeft|J[1], right = kRight|J[0].
REQ-019 SHALL drive P1 with no_rotate=1 as: up = kLeft|J[1], down = kRight|J[0], left = kDown|J[2], right = kUp|J[3].
REQ-020 SHALL drive p1_fire = kFire|J[4]; P2 from P2 keys OR J[3:0]/J[4], never rotated.
REQ-021 SHALL drive start1 = F1|"1"|J[5] and start2 = F2|"2"|J[6].
REQ-022 SHALL define coin request creq = "5"|"6"|J[7].
REQ-023 SHALL, on a creq rising edge with the stretcher idle, load the down-counter with COIN_MIN and assert coin1 on the next edge.
REQ-024 SHALL hold coin1 high while the counter is non-zero or creq is high; it falls on the first edge where both are zero.
REQ-025 SHALL NOT reload or extend the count on a creq rising edge while coin1 is high.
REQ-026 SHALL saturate the counter at zero (no wrap).

Reset
REQ-027 SHALL, while reset_n=0 at an edge, clear all key-state bits, the coin counter, all outputs and key_event.
REQ-028 SHALL load the toggle register with the current ps2_key[10] during reset, so no event is detected on the first cycle after release.
REQ-029 SHALL give reset priority over a coincident event or creq edge; a mid-stretch reset drops coin1 at that edge.

Structure
REQ-030 SHALL put scan-code constants, joystick bit indices and COIN_MIN default in package arcade_input_pkg.
REQ-031 SHALL implement the coin stretcher as sub-module coin_stretch (clk_sys, reset_n, req in, coin out, parameter COIN_MIN).

Verification
REQ-032 SHALL cover: ps2_key toggle with pressed=1, code 0x175 -> p1_up=1 two edges later and key_event pulses once; same code with pressed=0 -> p1_up=0.
REQ-033 SHALL cover: no_rotate=1 with joystick_0=16'h0008 -> p1_right=1, p1_up=0 one edge later; p2_up=1.
REQ-034 SHALL cover (COIN_MIN=10): creq pulse 1 cycle -> coin1 high exactly 10 cycles; creq held 25 cycles -> coin1 high 25 cycles.
REQ-035 SHALL cover: second creq edge at cycle 5 of a 10-cycle stretch -> coin1 still ends at cycle 10.
REQ-036 SHALL cover: toggle events on two consecutive cycles (0x029 press, 0x01C press) -> both p1_fire and p2_fire=1; unmapped 0x033 -> no key_event.
REQ-037 SHALL cover: reset_n=0 asserted mid-stretch with ps2_key[10]=1 -> all outputs 0; no event after reset_n=1 until the toggle changes.
